tuner_search_host: RTL and testbench

- Initiator end of the tuner search handshake: the requester side of what tuner_search_phy serves.
- Per ring channel, it loads the search window, issues the search trigger and waits for the peak report under a timeout.
- It then accepts the report, picks one peak (maximum power, or a fixed ordinal for row wavelength assignment) and hands the chosen lock code downstream on a valid/ready port.
- Retries automatically when a search returns zero peaks or times out.

---
 rtl/tuner_search_host.sv | 236 +++++++++++++++++++++++
 tb/tb_tuner_search_host.sv | 581 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tuner_search_host.sv
// tuner_search_host: host side of the tuner search handshake.
// Loads a window, triggers a search, then picks one peak as the lock code.
module tuner_search_host #(
    parameter int DAC_WIDTH     = 8,
    parameter int ADC_WIDTH     = 8,
    parameter int NUM_TARGET    = 4,
    parameter int TimeoutCycles = 4096,
    parameter int MaxRetry      = 2,
    localparam int IdxW = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1,
    localparam int CntW = $clog2(NUM_TARGET) + 1,
    localparam int RetW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1,
    localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_val,
    output logic                 o_cmd_rdy,
    input  logic                 i_cmd_mode,
    input  logic [IdxW-1:0]      i_cmd_idx,
    input  logic [DAC_WIDTH-1:0] i_cmd_start,
    input  logic [DAC_WIDTH-1:0] i_cmd_end,
    input  logic [DAC_WIDTH-1:0] i_cmd_stride,
    output logic [DAC_WIDTH-1:0] o_dig_ring_tune_start,
    output logic [DAC_WIDTH-1:0] o_dig_ring_tune_end,
    output logic [DAC_WIDTH-1:0] o_dig_ring_tune_stride,
    output logic                 o_dig_search_trig_val,
    input  logic                 i_dig_search_peaks_val,
    output logic                 o_dig_search_peaks_rdy,
    input  logic [DAC_WIDTH-1:0] i_dig_ring_tune_peaks [NUM_TARGET],
    input  logic [ADC_WIDTH-1:0] i_dig_pwr_detected_peaks [NUM_TARGET],
    input  logic [CntW-1:0]      i_dig_ring_tune_peaks_cnt,
    output logic                 o_lock_val,
    input  logic                 i_lock_rdy,
    output logic [DAC_WIDTH-1:0] o_lock_tune,
    output logic [ADC_WIDTH-1:0] o_lock_pwr,
    output logic                 o_err,
    output logic [2:0]           o_mon_state,
    output logic [RetW-1:0]      o_mon_retry
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_CAPT,
        ST_SCAN,
        ST_OUT,
        ST_RETRY,
        ST_FAIL
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic                 mode_q;
    logic [IdxW-1:0]      idx_q;
    logic [TmoW-1:0]      tmo_q;
    logic [RetW-1:0]      retry_q;
    logic [CntW-1:0]      ptr_q;
    logic [CntW-1:0]      cnt_q;
    logic [DAC_WIDTH-1:0] tune_q [NUM_TARGET];
    logic [ADC_WIDTH-1:0] pwr_q  [NUM_TARGET];

    logic [CntW-1:0] cnt_in;
    logic [IdxW-1:0] ptr_idx;
    logic            tmo_last;
    logic            retry_ok;
    logic            idx_ok;
    logic            scan_last;

    // A malformed count above the slot total is clamped to the slot total.
    assign cnt_in = (i_dig_ring_tune_peaks_cnt > CntW'(NUM_TARGET))
                  ? CntW'(NUM_TARGET)
                  : i_dig_ring_tune_peaks_cnt;

    assign ptr_idx   = ptr_q[IdxW-1:0];
    assign tmo_last  = (tmo_q == TmoW'(TimeoutCycles - 1));
    assign retry_ok  = (retry_q < RetW'(MaxRetry));
    assign idx_ok    = (CntW'(idx_q) < cnt_q);
    assign scan_last = ((ptr_q + CntW'(1)) >= cnt_q);

    assign o_mon_state = state_q;
    assign o_mon_retry = retry_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt              = state_q;
        o_cmd_rdy              = 1'b0;
        o_dig_search_trig_val  = 1'b0;
        o_dig_search_peaks_rdy = 1'b0;
        o_lock_val             = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_cmd_rdy = 1'b1;
                if (i_cmd_val) begin
                    state_nxt = ST_TRIG;
                end
            end
            ST_TRIG: begin
                o_dig_search_trig_val = 1'b1;
                state_nxt             = ST_WAIT;
            end
            ST_WAIT: begin
                o_dig_search_peaks_rdy = 1'b1;
                if (i_dig_search_peaks_val) begin
                    state_nxt = ST_CAPT;
                end else if (tmo_last) begin
                    state_nxt = ST_RETRY;
                end
            end
            ST_CAPT: begin
                if (cnt_q == '0) begin
                    state_nxt = ST_RETRY;
                end else if (mode_q) begin
                    state_nxt = idx_ok ? ST_OUT : ST_FAIL;
                end else if (cnt_q == CntW'(1)) begin
                    state_nxt = ST_OUT;
                end else begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                o_lock_val = 1'b1;
                if (i_lock_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RETRY: begin
                state_nxt = retry_ok ? ST_TRIG : ST_FAIL;
            end
            ST_FAIL: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode_q                 <= 1'b0;
            idx_q                  <= '0;
            tmo_q                  <= '0;
            retry_q                <= '0;
            ptr_q                  <= '0;
            cnt_q                  <= '0;
            o_dig_ring_tune_start  <= '0;
            o_dig_ring_tune_end    <= '0;
            o_dig_ring_tune_stride <= '0;
            o_lock_tune            <= '0;
            o_lock_pwr             <= '0;
            o_err                  <= 1'b0;
            for (int i = 0; i < NUM_TARGET; i++) begin
                tune_q[i] <= '0;
                pwr_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_cmd_val) begin
                        mode_q                 <= i_cmd_mode;
                        idx_q                  <= i_cmd_idx;
                        o_dig_ring_tune_start  <= i_cmd_start;
                        o_dig_ring_tune_end    <= i_cmd_end;
                        o_dig_ring_tune_stride <= i_cmd_stride;
                        o_err                  <= 1'b0;
                        retry_q                <= '0;
                    end
                end
                ST_TRIG: begin
                    tmo_q <= '0;
                end
                ST_WAIT: begin
                    // A report on the terminal-count cycle still wins.
                    if (i_dig_search_peaks_val) begin
                        cnt_q <= cnt_in;
                        for (int i = 0; i < NUM_TARGET; i++) begin
                            tune_q[i] <= i_dig_ring_tune_peaks[i];
                            pwr_q[i]  <= i_dig_pwr_detected_peaks[i];
                        end
                    end else if (!tmo_last) begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                ST_CAPT: begin
                    if (cnt_q != '0) begin
                        if (mode_q) begin
                            if (idx_ok) begin
                                o_lock_tune <= tune_q[idx_q];
                                o_lock_pwr  <= pwr_q[idx_q];
                            end
                        end else begin
                            o_lock_tune <= tune_q[0];
                            o_lock_pwr  <= pwr_q[0];
                            ptr_q       <= CntW'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    // Strictly greater: on a tie the lower slot is kept.
                    if (ptr_q < cnt_q) begin
                        if (pwr_q[ptr_idx] > o_lock_pwr) begin
                            o_lock_tune <= tune_q[ptr_idx];
                            o_lock_pwr  <= pwr_q[ptr_idx];
                        end
                        ptr_q <= ptr_q + CntW'(1);
                    end
                end
                ST_RETRY: begin
                    if (retry_ok) begin
                        retry_q <= retry_q + RetW'(1);
                    end
                end
                ST_FAIL: begin
                    o_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuner_search_host.sv
// tb_tuner_search_host: directed and randomized checks of the search host
// against a behavioural model of the peak-selection rules.
module tb_tuner_search_host;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int NT  = 4;
    localparam int TMO = 16;
    localparam int MR  = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          cmd_val    = 1'b0;
    logic          cmd_mode   = 1'b0;
    logic [1:0]    cmd_idx    = '0;
    logic [DW-1:0] cmd_start  = '0;
    logic [DW-1:0] cmd_end    = '0;
    logic [DW-1:0] cmd_stride = '0;
    logic          peaks_val  = 1'b0;
    logic [2:0]    pk_cnt     = '0;
    logic          lock_rdy   = 1'b0;
    logic [DW-1:0] pk_tune [NT];
    logic [AW-1:0] pk_pwr  [NT];

    logic          cmd_rdy;
    logic [DW-1:0] win_start;
    logic [DW-1:0] win_end;
    logic [DW-1:0] win_stride;
    logic          trig;
    logic          peaks_rdy;
    logic          lock_val;
    logic [DW-1:0] lock_tune;
    logic [AW-1:0] lock_pwr;
    logic          err;
    logic [2:0]    mon_state;
    logic [1:0]    mon_retry;

    int n_vec = 0;
    int n_err = 0;
    int trig_cnt = 0;
    int lock_rise = 0;
    logic lock_prev = 1'b0;

    int r_tune [NT];
    int r_pwr  [NT];
    int r_cnt;

    tuner_search_host #(
        .DAC_WIDTH(DW),
        .ADC_WIDTH(AW),
        .NUM_TARGET(NT),
        .TimeoutCycles(TMO),
        .MaxRetry(MR)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_cmd_val(cmd_val),
        .o_cmd_rdy(cmd_rdy),
        .i_cmd_mode(cmd_mode),
        .i_cmd_idx(cmd_idx),
        .i_cmd_start(cmd_start),
        .i_cmd_end(cmd_end),
        .i_cmd_stride(cmd_stride),
        .o_dig_ring_tune_start(win_start),
        .o_dig_ring_tune_end(win_end),
        .o_dig_ring_tune_stride(win_stride),
        .o_dig_search_trig_val(trig),
        .i_dig_search_peaks_val(peaks_val),
        .o_dig_search_peaks_rdy(peaks_rdy),
        .i_dig_ring_tune_peaks(pk_tune),
        .i_dig_pwr_detected_peaks(pk_pwr),
        .i_dig_ring_tune_peaks_cnt(pk_cnt),
        .o_lock_val(lock_val),
        .i_lock_rdy(lock_rdy),
        .o_lock_tune(lock_tune),
        .o_lock_pwr(lock_pwr),
        .o_err(err),
        .o_mon_state(mon_state),
        .o_mon_retry(mon_retry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        lock_prev <= lock_val;
        if (trig) trig_cnt <= trig_cnt + 1;
        if (lock_val && !lock_prev) lock_rise <= lock_rise + 1;
    end

    // Expected selection: highest power, lowest slot among equals;
    // ordinal mode takes the slot directly if it exists.
    function automatic void model_select(input bit mode, input int idx,
                                         output bit ok, output int et,
                                         output int ep);
        int best;
        ok = 0; et = 0; ep = 0;
        if (r_cnt == 0) return;
        if (mode) begin
            if (idx < r_cnt) begin
                ok = 1; et = r_tune[idx]; ep = r_pwr[idx];
            end
            return;
        end
        best = -1;
        for (int i = 0; i < r_cnt; i++)
            if (r_pwr[i] > best) best = r_pwr[i];
        for (int i = r_cnt - 1; i >= 0; i--)
            if (r_pwr[i] == best) et = r_tune[i];
        ok = 1; ep = best;
    endfunction

    task automatic issue(input bit mode, input int idx, input int s,
                         input int e, input int st);
        cmd_mode   = mode;
        cmd_idx    = 2'(idx);
        cmd_start  = 8'(s);
        cmd_end    = 8'(e);
        cmd_stride = 8'(st);
        cmd_val    = 1'b1;
        @(negedge clk);
        cmd_val    = 1'b0;
    endtask

    task automatic send_report();
        pk_cnt = 3'(r_cnt);
        for (int i = 0; i < NT; i++) begin
            pk_tune[i] = 8'(r_tune[i]);
            pk_pwr[i]  = 8'(r_pwr[i]);
        end
        peaks_val = 1'b1;
        @(negedge clk);
        peaks_val = 1'b0;
    endtask

    task automatic wait_trig(input int budget, output int cyc, output bit ok);
        ok = 0; cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (trig) begin
                ok = 1; cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic wait_lock(input int budget, output int cyc, output bit ok);
        ok = 0; cyc = 0;
        while (cyc < budget) begin
            if (lock_val) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_rdy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        lock_rdy = 1'b1;
        @(negedge clk);
        lock_rdy = 1'b0;
    endtask

    task automatic resync();
        cmd_val = 0; peaks_val = 0; lock_rdy = 0;
        @(negedge clk);
        if (!cmd_rdy) begin
            rst_n = 0;
            @(negedge clk);
            rst_n = 1;
            @(negedge clk);
        end
    endtask

    task automatic rand_report(input int cnt);
        r_cnt = cnt;
        for (int i = 0; i < NT; i++) begin
            r_tune[i] = $urandom_range(0, 255);
            r_pwr[i]  = $urandom_range(0, 3) * 60;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({cmd_rdy, trig, peaks_rdy, lock_val, err, mon_state, mon_retry}
            !== {1'b1, 9'b0}) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy=%b trig=%b prdy=%b lv=%b err=%b st=%0d rt=%0d want 1,0...",
                     cmd_rdy, trig, peaks_rdy, lock_val, err, mon_state, mon_retry);
        end
        n_vec++;
        if ({lock_tune, lock_pwr, win_start, win_end, win_stride} !== 40'b0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0",
                     {lock_tune, lock_pwr, win_start, win_end, win_stride});
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_max_power();
        int t0, c, et, ep;
        bit ok, mok;
        resync();
        r_tune = '{10, 55, 90, 0};
        r_pwr  = '{40, 200, 200, 0};
        r_cnt  = 3;
        model_select(0, 0, mok, et, ep);
        t0 = trig_cnt;
        issue(0, 0, 5, 200, 3);
        n_vec++;
        if (trig !== 1'b1) begin
            n_err++; $display("FAIL max_trig: got %b want 1", trig);
        end
        @(negedge clk);
        n_vec++;
        if (trig !== 1'b0 || peaks_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL max_wait: got trig=%b prdy=%b want 0,1", trig, peaks_rdy);
        end
        repeat (4) @(negedge clk);
        send_report();
        wait_lock(20, c, ok);
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL max_lock: got no lock_val want lock_val");
        end
        n_vec++;
        if (lock_tune !== 8'(et) || lock_pwr !== 8'(ep)) begin
            n_err++;
            $display("FAIL max_sel: got %0d/%0d want %0d/%0d", lock_tune, lock_pwr, et, ep);
        end
        n_vec++;
        if ({err, win_start, win_end, win_stride} !== {1'b0, 8'd5, 8'd200, 8'd3}) begin
            n_err++;
            $display("FAIL max_win: got err=%b %0d %0d %0d want 0 5 200 3",
                     err, win_start, win_end, win_stride);
        end
        handshake();
        n_vec++;
        if (cmd_rdy !== 1'b1 || lock_val !== 1'b0 || trig_cnt - t0 != 1) begin
            n_err++;
            $display("FAIL max_done: got rdy=%b lv=%b trigs=%0d want 1,0,1",
                     cmd_rdy, lock_val, trig_cnt - t0);
        end
    endtask

    task automatic test_ordinal();
        int c, l0, et, ep;
        bit ok, mok;
        resync();
        r_tune = '{12, 70, 130, 200};
        r_pwr  = '{9, 250, 33, 180};
        r_cnt  = 4;
        model_select(1, 2, mok, et, ep);
        issue(1, 2, 0, 255, 1);
        @(negedge clk);
        send_report();
        wait_lock(20, c, ok);
        n_vec++;
        if (!ok || c != 1) begin
            n_err++; $display("FAIL ord_latency: got ok=%b cyc=%0d want 1,1", ok, c);
        end
        n_vec++;
        if (lock_tune !== 8'(et) || lock_pwr !== 8'(ep)) begin
            n_err++;
            $display("FAIL ord_sel: got %0d/%0d want %0d/%0d", lock_tune, lock_pwr, et, ep);
        end
        handshake();
        r_cnt = 2;
        l0 = lock_rise;
        issue(1, 2, 0, 255, 1);
        @(negedge clk);
        send_report();
        wait_idle(20, ok);
        @(negedge clk);
        n_vec++;
        if (!ok || err !== 1'b1 || lock_rise != l0) begin
            n_err++;
            $display("FAIL ord_range: got idle=%b err=%b locks=%0d want 1,1,0",
                     ok, err, lock_rise - l0);
        end
    endtask

    task automatic test_zero_retry();
        int t0, l0, c, et, ep;
        bit ok, mok;
        resync();
        rand_report(0);
        t0 = trig_cnt;
        l0 = lock_rise;
        issue(0, 0, 20, 120, 2);
        for (int a = 0; a <= MR; a++) begin
            if (a > 0) begin
                wait_trig(40, c, ok);
                n_vec++;
                if (!ok) begin
                    n_err++; $display("FAIL zr_retrig: got none want attempt %0d", a);
                end
            end
            n_vec++;
            if (mon_retry !== 2'(a)) begin
                n_err++; $display("FAIL zr_count: got %0d want %0d", mon_retry, a);
            end
            @(negedge clk);
            send_report();
        end
        wait_idle(40, ok);
        @(negedge clk);
        n_vec++;
        if (!ok || err !== 1'b1 || mon_retry !== 2'(MR)) begin
            n_err++;
            $display("FAIL zr_fail: got idle=%b err=%b rt=%0d want 1,1,%0d",
                     ok, err, mon_retry, MR);
        end
        n_vec++;
        if (trig_cnt - t0 != MR + 1 || lock_rise != l0) begin
            n_err++;
            $display("FAIL zr_pulses: got trigs=%0d locks=%0d want %0d,0",
                     trig_cnt - t0, lock_rise - l0, MR + 1);
        end
        rand_report(0);
        t0 = trig_cnt;
        issue(0, 0, 20, 120, 2);
        @(negedge clk);
        send_report();
        wait_trig(40, c, ok);
        n_vec++;
        if (!ok || mon_retry !== 2'd1) begin
            n_err++; $display("FAIL zr_second: got ok=%b rt=%0d want 1,1", ok, mon_retry);
        end
        rand_report(1);
        r_tune[0] = 77;
        model_select(0, 0, mok, et, ep);
        @(negedge clk);
        send_report();
        wait_lock(20, c, ok);
        n_vec++;
        if (!ok || lock_tune !== 8'(et) || err !== 1'b0 || trig_cnt - t0 != 2) begin
            n_err++;
            $display("FAIL zr_recover: got ok=%b tune=%0d err=%b trigs=%0d want 1,%0d,0,2",
                     ok, lock_tune, err, trig_cnt - t0, et);
        end
        handshake();
    endtask

    task automatic test_timeout();
        int t0, c, et, ep;
        bit ok, mok;
        resync();
        t0 = trig_cnt;
        issue(0, 0, 1, 2, 3);
        for (int a = 1; a <= MR; a++) begin
            wait_trig(60, c, ok);
            n_vec++;
            if (!ok || c != TMO + 2) begin
                n_err++;
                $display("FAIL tmo_period: got ok=%b gap=%0d want 1,%0d", ok, c, TMO + 2);
            end
        end
        wait_idle(60, ok);
        @(negedge clk);
        n_vec++;
        if (!ok || err !== 1'b1 || trig_cnt - t0 != MR + 1) begin
            n_err++;
            $display("FAIL tmo_fail: got idle=%b err=%b trigs=%0d want 1,1,%0d",
                     ok, err, trig_cnt - t0, MR + 1);
        end
        rand_report(2);
        model_select(0, 0, mok, et, ep);
        t0 = trig_cnt;
        issue(0, 0, 1, 2, 3);
        repeat (TMO) @(negedge clk);
        n_vec++;
        if (peaks_rdy !== 1'b1) begin
            n_err++; $display("FAIL tmo_edge_rdy: got %b want 1", peaks_rdy);
        end
        send_report();
        wait_lock(20, c, ok);
        n_vec++;
        if (!ok || lock_tune !== 8'(et) || lock_pwr !== 8'(ep) || trig_cnt - t0 != 1) begin
            n_err++;
            $display("FAIL tmo_edge_cap: got ok=%b %0d/%0d trigs=%0d want 1,%0d/%0d,1",
                     ok, lock_tune, lock_pwr, trig_cnt - t0, et, ep);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int t0, c, et, ep;
        bit ok, mok;
        resync();
        rand_report(4);
        model_select(0, 0, mok, et, ep);
        issue(0, 0, 33, 66, 9);
        @(negedge clk);
        send_report();
        wait_lock(20, c, ok);
        t0 = trig_cnt;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (lock_val !== 1'b1 || lock_tune !== 8'(et) || lock_pwr !== 8'(ep) ||
                cmd_rdy !== 1'b0 || peaks_rdy !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got lv=%b %0d/%0d rdy=%b prdy=%b want 1,%0d/%0d,0,0",
                         i, lock_val, lock_tune, lock_pwr, cmd_rdy, peaks_rdy, et, ep);
            end
            if (i == 3) begin
                cmd_start = 8'd1; cmd_end = 8'd2; cmd_stride = 8'd4;
                cmd_val   = 1'b1;
                pk_cnt    = 3'd4;
                for (int k = 0; k < NT; k++) begin
                    pk_tune[k] = 8'(k + 1);
                    pk_pwr[k]  = 8'd255;
                end
                peaks_val = 1'b1;
            end
            if (i == 7) begin
                cmd_val = 1'b0; peaks_val = 1'b0;
            end
            @(negedge clk);
        end
        handshake();
        @(negedge clk);
        n_vec++;
        if (cmd_rdy !== 1'b1 || trig_cnt != t0 ||
            {win_start, win_end, win_stride} !== {8'd33, 8'd66, 8'd9}) begin
            n_err++;
            $display("FAIL bp_stray: got rdy=%b trigs=%0d win=%0d/%0d/%0d want 1,0,33/66/9",
                     cmd_rdy, trig_cnt - t0, win_start, win_end, win_stride);
        end
    endtask

    task automatic test_reset_mid();
        int c, et, ep;
        bit ok, mok;
        resync();
        rand_report(4);
        issue(0, 0, 7, 8, 9);
        @(negedge clk);
        send_report();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        n_vec++;
        if ({cmd_rdy, trig, peaks_rdy, lock_val, err, mon_state, mon_retry} !== {1'b1, 9'b0} ||
            {lock_tune, lock_pwr, win_start, win_end, win_stride} !== 40'b0) begin
            n_err++;
            $display("FAIL rst_scan: got rdy=%b st=%0d lv=%b data=%h want 1,0,0,0",
                     cmd_rdy, mon_state, lock_val,
                     {lock_tune, lock_pwr, win_start, win_end, win_stride});
        end
        rst_n = 1;
        @(negedge clk);
        rand_report(3);
        issue(0, 0, 7, 8, 9);
        @(negedge clk);
        rst_n = 0;
        pk_cnt = 3'd3;
        peaks_val = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({cmd_rdy, trig, peaks_rdy, lock_val, err, mon_state, mon_retry} !== {1'b1, 9'b0}) begin
            n_err++;
            $display("FAIL rst_wait: got rdy=%b prdy=%b st=%0d want 1,0,0",
                     cmd_rdy, peaks_rdy, mon_state);
        end
        rst_n = 1;
        @(negedge clk);
        peaks_val = 1'b0;
        n_vec++;
        if (cmd_rdy !== 1'b1 || peaks_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_drop: got rdy=%b prdy=%b want 1,0", cmd_rdy, peaks_rdy);
        end
        rand_report(3);
        model_select(0, 0, mok, et, ep);
        issue(0, 0, 11, 22, 1);
        @(negedge clk);
        send_report();
        wait_lock(20, c, ok);
        n_vec++;
        if (!ok || lock_tune !== 8'(et) || lock_pwr !== 8'(ep)) begin
            n_err++;
            $display("FAIL rst_resume: got ok=%b %0d/%0d want 1,%0d/%0d",
                     ok, lock_tune, lock_pwr, et, ep);
        end
        handshake();
    endtask

    task automatic test_random();
        int c, l0, et, ep, idx, dly, hold, s, e, st, cnt;
        bit ok, mok, mode;
        resync();
        for (int it = 0; it < 30; it++) begin
            mode = 1'($urandom_range(0, 1));
            idx  = $urandom_range(0, 3);
            dly  = (it == 0) ? 0 : $urandom_range(0, 5);
            hold = $urandom_range(0, 3);
            cnt  = $urandom_range(1, 4);
            s    = $urandom_range(0, 255);
            e    = $urandom_range(0, 255);
            st   = $urandom_range(0, 255);
            rand_report(cnt);
            model_select(mode, idx, mok, et, ep);
            l0 = lock_rise;
            issue(mode, idx, s, e, st);
            @(negedge clk);
            repeat (dly) @(negedge clk);
            send_report();
            if (mok) begin
                wait_lock(30, c, ok);
                n_vec++;
                if (!ok || c != 1 + (mode ? 0 : cnt - 1)) begin
                    n_err++;
                    $display("FAIL rnd_latency[%0d]: got ok=%b cyc=%0d want 1,%0d",
                             it, ok, c, 1 + (mode ? 0 : cnt - 1));
                end
                n_vec++;
                if (lock_tune !== 8'(et) || lock_pwr !== 8'(ep) || err !== 1'b0 ||
                    {win_start, win_end, win_stride} !== {8'(s), 8'(e), 8'(st)}) begin
                    n_err++;
                    $display("FAIL rnd_sel[%0d]: got %0d/%0d err=%b want %0d/%0d,0",
                             it, lock_tune, lock_pwr, err, et, ep);
                end
                repeat (hold) @(negedge clk);
                handshake();
                n_vec++;
                if (cmd_rdy !== 1'b1) begin
                    n_err++; $display("FAIL rnd_idle[%0d]: got %b want 1", it, cmd_rdy);
                end
            end else begin
                wait_idle(20, ok);
                @(negedge clk);
                n_vec++;
                if (!ok || err !== 1'b1 || lock_rise != l0) begin
                    n_err++;
                    $display("FAIL rnd_fail[%0d]: got idle=%b err=%b locks=%0d want 1,1,0",
                             it, ok, err, lock_rise - l0);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NT; i++) begin
            pk_tune[i] = '0;
            pk_pwr[i]  = '0;
        end
        test_reset();
        test_max_power();
        test_ordinal();
        test_zero_retry();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run want finish");
        $fatal(1);
    end

endmodule
